o_serializer: RTL and testbench

Periphery-side output serializer that consumes the single-bit-per-lane stream crossing the fabric-to-periphery marker buffer in parallel-word form and shifts it out LSB-first onto one pad-facing bit. It accepts whole words over a valid/ready handshake into a one-entry holding buffer, so consecutive words shift out with no gap. Each word carries its own output-enable, which follows its data to the pad.

---
 rtl/o_serializer_pkg.sv | 25 ++
 rtl/o_serializer_hold.sv | 39 +++
 rtl/o_serializer.sv | 111 +++++++++++
 tb/tb_o_serializer.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/o_serializer_pkg.sv
// Shared types and constants for the o_serializer output path.
// State encoding, legal word-width range and the bit-counter width.
package o_serializer_pkg;

   typedef enum logic {
      IDLE  = 1'b0,
      SHIFT = 1'b1
   } ser_state_e;

   localparam int WIDTH_MIN = 3;
   localparam int WIDTH_MAX = 10;

   function automatic int clog2(input int n);
      int r;
      r = 0;
      for (int v = n - 1; v > 0; v = v >> 1) begin
         r = r + 1;
      end
      return r;
   endfunction

   // Sized for the widest legal word so every instance shares one counter type.
   localparam int CNT_W = clog2(WIDTH_MAX);

endpackage

// File: rtl/o_serializer_hold.sv
// One-entry holding buffer for o_serializer: stores {OE, data} of the next word.
// Accepts on valid && ready; the shifter side empties it with a pop.
module o_serializer_hold
   import o_serializer_pkg::*;
#(
   parameter int WIDTH = 8
)(
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] d,
   input  logic             oe_in,
   input  logic             valid,
   input  logic             pop,
   output logic [WIDTH-1:0] hold_data,
   output logic             hold_oe,
   output logic             hold_v,
   output logic             ready
);

   logic [WIDTH:0] hold_word;

   // Accept and pop are mutually exclusive: accept needs an empty slot, pop a full one.
   always_ff @(posedge clk) begin
      if (rst) begin
         hold_word <= '0;
         hold_v    <= 1'b0;
      end else if (valid && !hold_v) begin
         hold_word <= {oe_in, d};
         hold_v    <= 1'b1;
      end else if (pop) begin
         hold_v    <= 1'b0;
      end
   end

   assign hold_data = hold_word[WIDTH-1:0];
   assign hold_oe   = hold_word[WIDTH];
   assign ready     = ~hold_v;

endmodule

// File: rtl/o_serializer.sv
// Parallel-to-serial pad driver, LSB first, with per-word output enable.
// Optional sticky gap flag UNDERRUN when O_SERIALIZER_UNDERRUN_EN is defined.
//
// state | meaning
// IDLE  | no word shifting; Q = IDLE_VAL, OE_OUT = 0
// SHIFT | word on the pad; cnt = index of the bit currently on Q
module o_serializer
   import o_serializer_pkg::*;
#(
   parameter int   WIDTH    = 8,
   parameter logic IDLE_VAL = 1'b0
)(
   input  logic             CLK,
   input  logic             RST,
   input  logic [WIDTH-1:0] D,
   input  logic             OE_IN,
   input  logic             DATA_VALID,
   output logic             DATA_READY,
   output logic             Q,
   output logic             OE_OUT,
   output logic             BUSY
`ifdef O_SERIALIZER_UNDERRUN_EN
   ,
   output logic             UNDERRUN
`endif
);

   if (WIDTH < WIDTH_MIN || WIDTH > WIDTH_MAX) begin : g_width_check
      $error("o_serializer: WIDTH %0d outside %0d..%0d", WIDTH, WIDTH_MIN, WIDTH_MAX);
   end

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

   ser_state_e       state;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-2:0] shifter;
   logic             q_r;
   logic             word_oe;

   logic [WIDTH-1:0] hold_data;
   logic             hold_oe;
   logic             hold_v;
   logic             load;

   o_serializer_hold #(
      .WIDTH (WIDTH)
   ) u_hold (
      .clk       (CLK),
      .rst       (RST),
      .d         (D),
      .oe_in     (OE_IN),
      .valid     (DATA_VALID),
      .pop       (load),
      .hold_data (hold_data),
      .hold_oe   (hold_oe),
      .hold_v    (hold_v),
      .ready     (DATA_READY)
   );

   assign load = hold_v && (state == IDLE || cnt == CNT_LAST);

   // Bit 0 goes straight to the Q flop on load, so the shifter only keeps the bits still to come.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= IDLE;
         cnt     <= '0;
         shifter <= '0;
         q_r     <= IDLE_VAL;
         word_oe <= 1'b0;
      end else if (load) begin
         state   <= SHIFT;
         cnt     <= '0;
         shifter <= hold_data[WIDTH-1:1];
         q_r     <= hold_data[0];
         word_oe <= hold_oe;
      end else if (state == SHIFT) begin
         if (cnt == CNT_LAST) begin
            state   <= IDLE;
            cnt     <= '0;
            q_r     <= IDLE_VAL;
            word_oe <= 1'b0;
         end else begin
            cnt     <= cnt + 1'b1;
            shifter <= shifter >> 1;
            q_r     <= shifter[0];
         end
      end
   end

   assign Q      = q_r;
   assign OE_OUT = word_oe;
   assign BUSY   = (state == SHIFT);

`ifdef O_SERIALIZER_UNDERRUN_EN
   logic underrun;

   // A word arriving on the very edge the pad goes idle was too late to avoid a gap.
   always_ff @(posedge CLK) begin
      if (RST) begin
         underrun <= 1'b0;
      end else if (state == SHIFT && cnt == CNT_LAST && !hold_v && DATA_VALID) begin
         underrun <= 1'b1;
      end
   end

   assign UNDERRUN = underrun;
`else
   // Gap tracking not built; idle gaps between words go unreported.
`endif

endmodule

// File: tb/tb_o_serializer.sv
// Bench for o_serializer: three widths (8/idle 0, 3/idle 1, 10/idle 1) against a bit-queue model.
// UNDERRUN checks are compiled only with O_SERIALIZER_UNDERRUN_EN.
module tb_o_serializer;

   localparam int   WID   [3] = '{8, 3, 10};
   localparam logic IDLEV [3] = '{1'b0, 1'b1, 1'b1};

   logic            clk;
   logic            rst;
   logic [2:0][9:0] d_in;
   logic [2:0]      oe_i;
   logic [2:0]      vld;
   logic [2:0]      rdy_o;
   logic [2:0]      q_o;
   logic [2:0]      oe_o;
   logic [2:0]      busy_o;
`ifdef O_SERIALIZER_UNDERRUN_EN
   logic [2:0]      und_o;
`endif

   int total = 0;
   int bad   = 0;

   // model: per DUT, a list of {oe,bit} still to appear on the pad (front = on Q now)
   bit [1:0] pend   [3][12];
   int       pend_n [3];
   bit       m_hv   [3];
   bit [9:0] m_hd   [3];
   bit       m_hoe  [3];
   bit       m_und  [3];
   bit       m_acc  [3];

   logic [15:0] obs   [3];
   int          bcnt  [3];
   int          tog   [3];
   logic        pbusy [3];
   logic        poe   [3];
   logic [9:0]  words [3][4];

   o_serializer #(.WIDTH(8), .IDLE_VAL(1'b0)) dut0 (
      .CLK(clk), .RST(rst), .D(d_in[0][7:0]), .OE_IN(oe_i[0]), .DATA_VALID(vld[0]),
      .DATA_READY(rdy_o[0]), .Q(q_o[0]), .OE_OUT(oe_o[0]), .BUSY(busy_o[0])
`ifdef O_SERIALIZER_UNDERRUN_EN
      , .UNDERRUN(und_o[0])
`endif
   );

   o_serializer #(.WIDTH(3), .IDLE_VAL(1'b1)) dut1 (
      .CLK(clk), .RST(rst), .D(d_in[1][2:0]), .OE_IN(oe_i[1]), .DATA_VALID(vld[1]),
      .DATA_READY(rdy_o[1]), .Q(q_o[1]), .OE_OUT(oe_o[1]), .BUSY(busy_o[1])
`ifdef O_SERIALIZER_UNDERRUN_EN
      , .UNDERRUN(und_o[1])
`endif
   );

   o_serializer #(.WIDTH(10), .IDLE_VAL(1'b1)) dut2 (
      .CLK(clk), .RST(rst), .D(d_in[2]), .OE_IN(oe_i[2]), .DATA_VALID(vld[2]),
      .DATA_READY(rdy_o[2]), .Q(q_o[2]), .OE_OUT(oe_o[2]), .BUSY(busy_o[2])
`ifdef O_SERIALIZER_UNDERRUN_EN
      , .UNDERRUN(und_o[2])
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input int i);
      bit pre;
      bit was;
      m_acc[i] = 1'b0;
      if (rst) begin
         pend_n[i] = 0;
         m_hv[i]   = 1'b0;
         m_und[i]  = 1'b0;
         return;
      end
      pre      = m_hv[i];
      m_acc[i] = vld[i] && !m_hv[i];
      was      = pend_n[i] > 0;
      if (was) begin
         for (int j = 0; j < 11; j++) pend[i][j] = pend[i][j+1];
         pend_n[i]--;
      end
      if (pend_n[i] == 0 && pre) begin
         for (int b = 0; b < WID[i]; b++) pend[i][b] = {m_hoe[i], m_hd[i][b]};
         pend_n[i] = WID[i];
         m_hv[i]   = 1'b0;
      end
      if (was && pend_n[i] == 0 && vld[i]) m_und[i] = 1'b1;
      if (m_acc[i]) begin
         m_hv[i]  = 1'b1;
         m_hd[i]  = d_in[i];
         m_hoe[i] = oe_i[i];
      end
   endtask

   task automatic cycle();
      @(posedge clk);
      for (int i = 0; i < 3; i++) model_step(i);
      #1;
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("ready[%0d]", i), rdy_o[i], !m_hv[i]);
         chk($sformatf("busy[%0d]", i), busy_o[i], pend_n[i] > 0);
         chk($sformatf("q[%0d]", i), q_o[i], (pend_n[i] > 0) ? pend[i][0][0] : IDLEV[i]);
         chk($sformatf("oe[%0d]", i), oe_o[i], (pend_n[i] > 0) ? pend[i][0][1] : 1'b0);
`ifdef O_SERIALIZER_UNDERRUN_EN
         chk($sformatf("und[%0d]", i), und_o[i], m_und[i]);
`endif
         if (busy_o[i]) begin
            obs[i] = {q_o[i], obs[i][15:1]};
            bcnt[i]++;
            if (pbusy[i] && oe_o[i] !== poe[i]) tog[i]++;
         end
         pbusy[i] = busy_o[i];
         poe[i]   = oe_o[i];
      end
   endtask

   task automatic clr_stats();
      for (int i = 0; i < 3; i++) begin
         obs[i] = '0; bcnt[i] = 0; tog[i] = 0; pbusy[i] = 1'b0; poe[i] = 1'b0;
      end
   endtask

   // D/OE are scrambled whenever the DUT is not ready; only the value at the accept edge counts.
   task automatic stream(input bit [2:0] en, input int nw, input bit alt_oe);
      int idx [3];
      int c;
      for (int i = 0; i < 3; i++) idx[i] = 0;
      c = 0;
      while (c < 200 && ((en[0] && idx[0] < nw) || (en[1] && idx[1] < nw) || (en[2] && idx[2] < nw))) begin
         for (int i = 0; i < 3; i++) begin
            if (en[i] && idx[i] < nw) begin
               vld[i]  = 1'b1;
               d_in[i] = m_hv[i] ? 10'($urandom) : words[i][idx[i]];
               oe_i[i] = m_hv[i] ? 1'($urandom) : (alt_oe ? idx[i][0] : 1'b1);
            end else begin
               vld[i] = 1'b0;
            end
         end
         cycle();
         c++;
         for (int i = 0; i < 3; i++) if (en[i] && m_acc[i]) idx[i]++;
      end
      for (int i = 0; i < 3; i++) if (en[i]) chk($sformatf("words_accepted[%0d]", i), idx[i], nw);
   endtask

   initial begin
      rst  = 1'b1;
      vld  = '0;
      d_in = '0;
      oe_i = '0;
      clr_stats();
      repeat (2) cycle();
      rst = 1'b0;
      cycle();

      // single A5 word with OE
      clr_stats();
      words[0][0] = 10'h0A5;
      stream(3'b001, 1, 1'b0);
      vld = '0;
      repeat (12) cycle();
      chk("single_bits", obs[0][15:8], 8'hA5);
      chk("single_busy_len", bcnt[0], 8);
      chk("single_idle_q", q_o[0], 1'b0);

      // back-to-back A5, 3C
      clr_stats();
      words[0][0] = 10'h0A5;
      words[0][1] = 10'h03C;
      stream(3'b001, 2, 1'b0);
      vld = '0;
      repeat (20) cycle();
      chk("b2b_bits", obs[0], 16'h3CA5);
      chk("b2b_busy_len", bcnt[0], 16);

      // reset mid-word with a second word buffered
      words[0][0] = 10'h0F0;
      words[0][1] = 10'h055;
      stream(3'b001, 2, 1'b0);
      vld = '0;
      cycle();
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("rst_q", q_o[0], 1'b0);
      chk("rst_oe", oe_o[0], 1'b0);
      chk("rst_busy", busy_o[0], 1'b0);
      chk("rst_ready", rdy_o[0], 1'b1);
      clr_stats();
      repeat (12) cycle();
      chk("rst_dropped", bcnt[0], 0);

      // WIDTH 3 and 10 streaming 4 words, alternating OE
      clr_stats();
      for (int w = 0; w < 4; w++) begin
         words[1][w] = 10'($urandom);
         words[2][w] = 10'($urandom);
      end
      stream(3'b110, 4, 1'b1);
      vld = '0;
      repeat (40) cycle();
      chk("w3_busy_len", bcnt[1], 12);
      chk("w10_busy_len", bcnt[2], 40);
      chk("w3_oe_toggles", tog[1], 3);
      chk("w10_oe_toggles", tog[2], 3);
      chk("w3_idle_q", q_o[1], 1'b1);
      chk("w10_idle_q", q_o[2], 1'b1);

`ifdef O_SERIALIZER_UNDERRUN_EN
      // second word presented exactly on the last-bit edge
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      words[0][0] = 10'h05A;
      stream(3'b001, 1, 1'b0);
      vld = '0;
      repeat (8) cycle();
      vld[0]  = 1'b1;
      d_in[0] = 10'h0C3;
      oe_i[0] = 1'b1;
      cycle();
      vld = '0;
      chk("und_set", und_o[0], 1'b1);
      chk("und_gap_busy", busy_o[0], 1'b0);
      repeat (12) cycle();
      chk("und_sticky", und_o[0], 1'b1);
      rst = 1'b1;
      cycle();
      rst = 1'b0;
      chk("und_clear", und_o[0], 1'b0);
`endif

      // random traffic on all three widths with occasional reset
      for (int c = 0; c < 400; c++) begin
         rst = ($urandom_range(0, 99) == 0);
         for (int i = 0; i < 3; i++) begin
            vld[i]  = ($urandom_range(0, 3) != 0);
            d_in[i] = 10'($urandom);
            oe_i[i] = 1'($urandom);
         end
         cycle();
      end
      rst = 1'b0;
      vld = '0;
      repeat (15) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
